// File: rtl/peres_pkg.sv
// Shared Peres-gate types and helpers for the reversible adder.
// Gate model: P = a, Q = a^b, R = (a&b)^c.
package peres_pkg;

  typedef struct packed {
    logic p;
    logic q;
    logic r;
  } peres_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic peres_t peres(
    input logic a,
    input logic b,
    input logic c
  );
    peres_t g;
    g.p = a;
    g.q = a ^ b;
    g.r = (a & b) ^ c;
    return g;
  endfunction

  function automatic int seg_width(
    input int width,
    input int stages
  );
    return width / stages;
  endfunction

endpackage

// File: rtl/peres_fa_slice.sv
// SLICE-bit ripple of two-Peres full adders (combinational).
// Ports: a, b (b_eff), cin -> sum, cout, c_msb_in, g0 (P1), g1 (P2).
module peres_fa_slice
  import peres_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb_in,
  output logic [SLICE-1:0] g0,
  output logic [SLICE-1:0] g1
);

  logic [SLICE:0] c;
  peres_t         t1;
  peres_t         t2;

  always_comb begin
    c    = '0;
    c[0] = cin;
    sum  = '0;
    g0   = '0;
    g1   = '0;
    t1   = '0;
    t2   = '0;
    for (int i = 0; i < SLICE; i++) begin
      t1       = peres(a[i], b[i], 1'b0);
      t2       = peres(t1.q, c[i], t1.r);
      sum[i]   = t2.q;
      c[i+1]   = t2.r;
      g0[i]    = t1.p;
      g1[i]    = t2.p;
    end
  end

  assign cout     = c[SLICE];
  assign c_msb_in = c[SLICE-1];

endmodule

// File: rtl/peres_pipe_adder.sv
// Pipelined reversible add/sub built from Peres-gate full adders.
// Ports: valid/ready in (a,b,cin,op_sub), valid/ready out (sum,cout,ovf,garb).
module peres_pipe_adder
  import peres_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  input  logic               op_sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   sum,
  output logic               cout,
  output logic               ovf,
  output logic [2*WIDTH-1:0] garb
);

  localparam int SW = seg_width(WIDTH, STAGES);
  localparam int L  = STAGES - 1;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH ||
      WIDTH % STAGES != 0) begin : g_bad_cfg
    $error("peres_pipe_adder: illegal WIDTH/STAGES");
  end

  // Every register carries full-width words; bits above the
  // processed boundary of sum/garbage are don't-care until
  // a later segment fills them.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] g0;
    logic [WIDTH-1:0] g1;
    logic             carry;
    logic             cmsb;
  } seg_t;

  seg_t              seed;
  seg_t              src   [STAGES];
  seg_t              nxt   [STAGES];
  seg_t              seg_q [STAGES];
  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] vin;
  logic [STAGES:0]   rdy;

  assign seed = '{
    a:     a,
    b:     b ^ {WIDTH{op_sub == OP_SUB}},
    sum:   '0,
    g0:    '0,
    g1:    '0,
    carry: cin ^ (op_sub == OP_SUB),
    cmsb:  1'b0
  };

  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !valid[k] || rdy[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    localparam int LO = k * SW;

    logic [SW-1:0]    s;
    logic [SW-1:0]    p1;
    logic [SW-1:0]    p2;
    logic             co;
    logic             cm;
    logic [WIDTH-1:0] sum_n;
    logic [WIDTH-1:0] g0_n;
    logic [WIDTH-1:0] g1_n;

    if (k == 0) begin : g_first
      assign src[k] = seed;
      assign vin[k] = in_valid;
    end else begin : g_next
      assign src[k] = seg_q[k-1];
      assign vin[k] = valid[k-1];
    end

    peres_fa_slice #(
      .SLICE(SW)
    ) u_slice (
      .a        (src[k].a[LO +: SW]),
      .b        (src[k].b[LO +: SW]),
      .cin      (src[k].carry),
      .sum      (s),
      .cout     (co),
      .c_msb_in (cm),
      .g0       (p1),
      .g1       (p2)
    );

    always_comb begin
      sum_n           = src[k].sum;
      g0_n            = src[k].g0;
      g1_n            = src[k].g1;
      sum_n[LO +: SW] = s;
      g0_n[LO +: SW]  = p1;
      g1_n[LO +: SW]  = p2;
    end

    assign nxt[k] = '{
      a:     src[k].a,
      b:     src[k].b,
      sum:   sum_n,
      g0:    g0_n,
      g1:    g1_n,
      carry: co,
      cmsb:  cm
    };
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        seg_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          valid[k] <= vin[k];
          if (vin[k]) begin
            seg_q[k] <= nxt[k];
          end
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = valid[L];
  assign sum       = seg_q[L].sum;
  assign cout      = seg_q[L].carry;
  assign ovf       = seg_q[L].carry ^ seg_q[L].cmsb;
  assign garb      = {seg_q[L].g1, seg_q[L].g0};

endmodule

// File: doc/peres_pipe_adder.md
Name: peres_pipe_adder

Overview:
Parametrised WIDTH-bit reversible adder/subtractor. Each bit is a full adder built from two cascaded Peres gates. The carry chain is cut into STAGES registered segments, with a valid/ready handshake and full backpressure. It succeeds the fixed 4-bit Peres adder and is the arithmetic datapath for the reversible ALU; garbage lines are carried alongside the result for reversibility accounting.

Parameters:
WIDTH, 16, operand/result width in bits; must be ≥ 2.
STAGES, 4, number of pipeline segments; 1 ≤ STAGES ≤ WIDTH and WIDTH % STAGES == 0 (elaboration-time assertion).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands presented
in_ready  out  1  adder can accept this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in (add) / borrow-in (sub)
op_sub  in  1  0 = A+B+cin, 1 = A−B−cin
out_valid  out  1  result presented
out_ready  in  1  consumer accepts result
sum  out  WIDTH  result
cout  out  1  raw carry-out of MSB (sub: 1 = no borrow)
ovf  out  1  signed two's-complement overflow
garb  out  2*WIDTH  garbage lines {G1, G0}: G0[i] = a[i], G1[i] = a[i]^b_eff[i]

Behaviour:
- Operand conditioning: b_eff = b ^ {WIDTH{op_sub}}; c0 = cin ^ op_sub.
- Per bit i, gate 1 = peres(a[i], b_eff[i], 0) gives P = a, Q = a^b_eff, R = a&b_eff.
- Gate 2 = peres(Q, c_i, R) gives Q2 = sum[i] and R2 = c_{i+1}, i.e. (a^b)&c ^ a&b. Both gate-1 P and gate-2 P are garbage.
- sum, cout are bit-exact to (a + b_eff + c0) mod 2^(WIDTH+1).
- ovf = carry into MSB ^ carry out of MSB.
- Segment k (0-based) processes bits [k*W/S +: W/S]. Its register holds:
  - the partial sum and garbage for bits below the segment's upper bound;
  - the carry out of the segment;
  - the unconsumed a/b_eff upper bits;
  - a valid flag.
- Segment 0 is combinational from the inputs into register 0. Register S−1 drives the outputs directly, with no output logic after the register.
- Latency is exactly STAGES cycles from in_valid&&in_ready to out_valid when unstalled. Throughput is 1 transaction/cycle.
- Handshake:
  - ready_k = !valid_k || ready_{k+1}.
  - ready_S = out_ready; in_ready = ready_0.
  - A register loads only when its ready is high.
  - Outputs are held stable while out_valid && !out_ready.
  - in_ready is combinational from out_ready through the chain; no skid buffer.
- Transfers complete on in_valid&&in_ready and out_valid&&out_ready. Acceptance and output on the same cycle into a full pipe is legal and loses nothing.
- Bubbles: an invalid slot never raises out_valid. Data registers of empty slots may hold stale values; outputs are qualified by out_valid only.
- Reset values:
  - all valid flags 0, out_valid 0;
  - sum, cout, ovf, garb all 0;
  - in_ready 1 after reset release.
- Reset mid-operation: all in-flight transactions are discarded; no partial result is emitted.
- Order is strictly FIFO; no reordering or dropping under any stall pattern.
- Boundary cases:
  - all-ones + 1 in add mode gives sum 0, cout 1.
  - 0 − 0 with cin = 0 gives sum 0, cout 1.
  - STAGES = 1 gives a single-register ripple adder.
  - STAGES = WIDTH gives one bit per segment.

Decomposition:
- Package peres_pkg:
  - peres_t struct {p, q, r};
  - function peres(a, b, c) returning peres_t;
  - op encoding localparams OP_ADD = 1'b0, OP_SUB = 1'b1;
  - segment-width helper function.
- Sub-module peres_fa_slice: a combinational SLICE-bit ripple of two-Peres full adders, taking a, b_eff, cin and producing sum, cout, c_msb_in and garbage. It is instantiated once per segment via generate.

Test Plan:
- WIDTH=8, STAGES=2, add 8'hFF + 8'h01, cin=0 → sum 8'h00, cout 1, ovf 0, out_valid exactly 2 cycles after accept.
- Sub 8'h05 − 8'h07, cin=0 → sum 8'hFE, cout 0, ovf 0. Sub 8'h80 − 8'h01 → sum 8'h7F, cout 1, ovf 1.
- Garbage check: add a=8'hA5, b=8'h3C → garb = {8'h99, 8'hA5}. Sub with the same operands → garb = {8'h66, 8'hA5}.
- Backpressure: hold out_ready=0 and present 4 back-to-back transactions.
  - in_ready falls after 2 accepts; outputs stay stable.
  - Release out_ready: results emerge in order with no loss or duplication.
- Throughput: 100 random transactions with in_valid and out_ready held high → one result per cycle after 2-cycle fill. Results match the reference model, including ovf and cout.
- Reset: assert rst_n=0 for 1 cycle with 2 transactions in flight → out_valid 0 and all outputs 0 immediately. No stale result appears after release; in_ready=1.
